// File: rtl/mem_stage_if.sv
// Shared bus types and the handshake interface of the memory-response stage (mem_stage).
// Covers the pre-memory input bus, write-back/forwarding outputs, flush and data-SRAM response.
package mem_stage_pkg;

  typedef struct packed {
    logic mfc0;
    logic mtc0;
    logic eret;
  } c0_op_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] excode;
  } exception_t;

  typedef struct packed {
    logic tlbp;
    logic tlbr;
    logic tlbwi;
  } tlb_op_t;

  typedef struct packed {
    logic ex;
    logic eret;
  } pipeline_flush_t;

  // load_op is one-hot, bit 0 upward: lb, lbu, lh, lhu, lw, lwl, lwr
  typedef struct packed {
    logic        valid;
    logic [6:0]  load_op;
    c0_op_t      c0_op;
    logic [7:0]  c0_addr;
    logic        req_ok;
    logic        res_from_mem;
    logic        res_to_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    exception_t  exception;
    tlb_op_t     tlb_op;
  } pms_to_ms_bus_t;

  typedef struct packed {
    logic        valid;
    c0_op_t      c0_op;
    logic [7:0]  c0_addr;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    exception_t  exception;
    tlb_op_t     tlb_op;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        op_mfc0;
    logic        load_pending;
    logic        op_tlb;
    logic [4:0]  dest;
    logic [31:0] fwd_data;
  } ms_forward_bus_t;

endpackage

interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            ws_allowin;
  logic            ms_allowin;
  pms_to_ms_bus_t  pms_to_ms_bus;
  ms_to_ws_bus_t   ms_to_ws_bus;
  ms_forward_bus_t ms_forward_bus;
  pipeline_flush_t pipeline_flush;
  logic            ms_wr_disable;
  logic            data_data_ok;
  logic [31:0]     data_rdata;

  modport master (
    input  ws_allowin, pms_to_ms_bus, pipeline_flush, data_data_ok, data_rdata,
    output ms_allowin, ms_to_ws_bus, ms_forward_bus, ms_wr_disable
  );

  modport slave (
    output ws_allowin, pms_to_ms_bus, pipeline_flush, data_data_ok, data_rdata,
    input  ms_allowin, ms_to_ws_bus, ms_forward_bus, ms_wr_disable
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-response pipeline stage: captures data-SRAM responses, aligns load data, drops stale responses.
// Optional MEM_LOAD_FWD_EN forwards loaded data in the cycle it arrives instead of the raw ALU result.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic         clk,
  input logic         reset,
  mem_stage_if.master ms_if
);

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_READY
  } ms_state_e;

  logic            ms_valid;
  pms_to_ms_bus_t  bus_r;
  logic            data_got;
  logic [31:0]     rdata_r;
  logic [1:0]      discard_cnt;

  ms_state_e       ms_state;
  logic            flush;
  logic            resp_hit;
  logic            resp_drop;
  logic            ms_ready_go;
  logic            ms_allowin;
  logic            wait_lost;
  logic            stale_in;
  logic [2:0]      discard_sum;
  logic [31:0]     load_src;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [31:0]     load_data;
  logic [31:0]     final_result;
  ms_to_ws_bus_t   to_ws;
  ms_forward_bus_t fwd;
  logic            unused_bits;

  assign flush     = ms_if.pipeline_flush.ex | ms_if.pipeline_flush.eret;
  assign resp_hit  = ms_if.data_data_ok & (discard_cnt == 2'd0);
  assign resp_drop = ms_if.data_data_ok & (discard_cnt != 2'd0);

  always_comb begin
    ms_state = MS_IDLE;
    if (ms_valid) begin
      if (bus_r.req_ok && !data_got) ms_state = MS_WAIT;
      else                           ms_state = MS_READY;
    end
  end

  assign ms_ready_go = (ms_state != MS_WAIT) | resp_hit;
  assign ms_allowin  = !ms_valid | (ms_ready_go & ms_if.ws_allowin);

  // Every request whose response will never be delivered adds one stale response to skip
  assign wait_lost   = flush & (ms_state == MS_WAIT) & !resp_hit;
  assign stale_in    = flush & ms_if.pms_to_ms_bus.valid & ms_if.pms_to_ms_bus.req_ok;
  assign discard_sum = {1'b0, discard_cnt} + {2'b00, wait_lost} + {2'b00, stale_in}
                     - {2'b00, resp_drop};

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      data_got    <= 1'b0;
      discard_cnt <= 2'd0;
      bus_r       <= '0;
      rdata_r     <= '0;
    end else begin
      discard_cnt <= (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
      if (flush) begin
        ms_valid <= 1'b0;
        data_got <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= ms_if.pms_to_ms_bus.valid;
        data_got <= 1'b0;
      end else if (ms_state == MS_WAIT && resp_hit) begin
        data_got <= 1'b1;
      end
      if (ms_if.pms_to_ms_bus.valid && ms_allowin) bus_r <= ms_if.pms_to_ms_bus;
      if (ms_state == MS_WAIT && resp_hit) rdata_r <= ms_if.data_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (reset) discard_sum <= 3'd3);

  // lwl/lwr deliver shifted bytes only; write-back merges them using its byte enables
  always_comb begin
    load_src  = data_got ? rdata_r : ms_if.data_rdata;
    load_byte = load_src[{bus_r.result[1:0], 3'b000} +: 8];
    load_half = bus_r.result[1] ? load_src[31:16] : load_src[15:0];
    load_data = load_src;
    if (bus_r.load_op[0])      load_data = {{24{load_byte[7]}}, load_byte};
    else if (bus_r.load_op[1]) load_data = {24'h0, load_byte};
    else if (bus_r.load_op[2]) load_data = {{16{load_half[15]}}, load_half};
    else if (bus_r.load_op[3]) load_data = {16'h0, load_half};
    else if (bus_r.load_op[5]) load_data = load_src << {~bus_r.result[1:0], 3'b000};
    else if (bus_r.load_op[6]) load_data = load_src >> {bus_r.result[1:0], 3'b000};
    final_result = bus_r.res_from_mem ? load_data : bus_r.result;
  end

  always_comb begin
    to_ws              = '0;
    to_ws.valid        = ms_valid & ms_ready_go;
    to_ws.c0_op        = bus_r.c0_op;
    to_ws.c0_addr      = bus_r.c0_addr;
    to_ws.rf_we        = bus_r.rf_we;
    to_ws.dest         = bus_r.dest;
    to_ws.final_result = final_result;
    to_ws.pc           = bus_r.pc;
    to_ws.exception    = bus_r.exception;
    to_ws.tlb_op       = bus_r.tlb_op;

    fwd         = '0;
    fwd.op_mfc0 = ms_valid & bus_r.c0_op.mfc0;
    fwd.op_tlb  = ms_valid & (|bus_r.tlb_op);
    fwd.dest    = (ms_valid && bus_r.rf_we) ? bus_r.dest : 5'd0;
`ifdef MEM_LOAD_FWD_EN
    fwd.fwd_data     = final_result;
    fwd.load_pending = ms_valid & bus_r.res_from_mem & !ms_ready_go;
`else
    fwd.fwd_data     = bus_r.result;
    fwd.load_pending = ms_valid & bus_r.res_from_mem;
`endif
  end

  assign ms_if.ms_allowin     = ms_allowin;
  assign ms_if.ms_to_ws_bus   = to_ws;
  assign ms_if.ms_forward_bus = fwd;
  assign ms_if.ms_wr_disable  = ms_valid & (bus_r.exception.ex | bus_r.c0_op.eret);

  assign unused_bits = &{1'b0, bus_r.valid, bus_r.res_to_mem};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a response-ownership queue model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [6:0] OP_LB  = 7'b0000001;
  localparam logic [6:0] OP_LBU = 7'b0000010;
  localparam logic [6:0] OP_LH  = 7'b0000100;
  localparam logic [6:0] OP_LHU = 7'b0001000;
  localparam logic [6:0] OP_LW  = 7'b0010000;
  localparam logic [6:0] OP_LWL = 7'b0100000;
  localparam logic [6:0] OP_LWR = 7'b1000000;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if ms_if ();

  mem_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .ms_if (ms_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic pms_to_ms_bus_t mkLoad(input logic [6:0] op, input logic [31:0] addr,
                                            input logic [4:0] dest, input logic [31:0] pc);
    pms_to_ms_bus_t b = '0;
    b.valid = 1'b1; b.load_op = op; b.req_ok = 1'b1; b.res_from_mem = 1'b1;
    b.rf_we = 1'b1; b.dest = dest; b.result = addr; b.pc = pc;
    return b;
  endfunction

  function automatic pms_to_ms_bus_t mkAlu(input logic [31:0] res, input logic [4:0] dest,
                                           input logic [31:0] pc);
    pms_to_ms_bus_t b = '0;
    b.valid = 1'b1; b.rf_we = 1'b1; b.dest = dest; b.result = res; b.pc = pc;
    return b;
  endfunction

  // Reference load formatting written from the instruction definitions
  function automatic logic [31:0] modelLoad(input logic [6:0] op, input logic [1:0] addr,
                                            input logic [31:0] w);
    int a = int'(addr);
    logic [31:0] b = (w >> (8 * a)) & 32'h0000_00FF;
    logic [31:0] h = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
    case (op)
      OP_LB:   return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      OP_LWL:  return w << (8 * (3 - a));
      OP_LWR:  return w >> (8 * a);
      default: return w;
    endcase
  endfunction

  // Model: queue of outstanding responses, 1 = owned by the MEM instruction, 0 = stale
  int             owners[$];
  logic           m_valid = 1'b0;
  pms_to_ms_bus_t m_instr = '0;
  logic           m_have = 1'b0;
  logic [31:0]    m_data = '0;

  always @(negedge clk) begin
    logic        flush_now;
    logic        front_mine;
    logic        exp_go;
    logic        exp_allowin;
    logic [31:0] exp_final;
    logic [31:0] exp_fwd;
    logic        exp_lp;
    int          stale;
    int          owner;

    flush_now  = ms_if.pipeline_flush.ex | ms_if.pipeline_flush.eret;
    front_mine = ms_if.data_data_ok && owners.size() > 0 && owners[0] == 1;
    exp_go     = !m_instr.req_ok || m_have || front_mine;
    exp_allowin = !m_valid || (exp_go && ms_if.ws_allowin);
    exp_final  = m_instr.res_from_mem
               ? modelLoad(m_instr.load_op, m_instr.result[1:0],
                           m_have ? m_data : ms_if.data_rdata)
               : m_instr.result;
    stale = 0;
    foreach (owners[i]) if (owners[i] == 0) stale++;
    if (stale > 3) stale = 3;
`ifdef MEM_LOAD_FWD_EN
    exp_fwd = exp_final;
    exp_lp  = m_valid && m_instr.res_from_mem && !exp_go;
`else
    exp_fwd = m_instr.result;
    exp_lp  = m_valid && m_instr.res_from_mem;
`endif

    if (!reset) begin
      checkOutput("model_allowin", 32'(ms_if.ms_allowin), 32'(exp_allowin));
      checkOutput("model_ws_valid", 32'(ms_if.ms_to_ws_bus.valid), 32'(m_valid && exp_go));
      if (m_valid && exp_go) begin
        checkOutput("model_final_result", ms_if.ms_to_ws_bus.final_result, exp_final);
        checkOutput("model_ws_dest", 32'(ms_if.ms_to_ws_bus.dest), 32'(m_instr.dest));
        checkOutput("model_ws_pc", ms_if.ms_to_ws_bus.pc, m_instr.pc);
      end
      checkOutput("model_wr_disable", 32'(ms_if.ms_wr_disable),
                  32'(m_valid && (m_instr.exception.ex || m_instr.c0_op.eret)));
      checkOutput("model_fwd_dest", 32'(ms_if.ms_forward_bus.dest),
                  32'((m_valid && m_instr.rf_we) ? m_instr.dest : 5'd0));
      checkOutput("model_load_pending", 32'(ms_if.ms_forward_bus.load_pending), 32'(exp_lp));
      if (m_valid) checkOutput("model_fwd_data", ms_if.ms_forward_bus.fwd_data, exp_fwd);
      checkOutput("model_discard_cnt", 32'(u_dut.discard_cnt), 32'(stale));
    end

    if (reset) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
      owners.delete();
    end else begin
      owner = 0;
      if (ms_if.data_data_ok && owners.size() > 0) owner = owners.pop_front();
      if (flush_now) begin
        foreach (owners[i]) owners[i] = 0;
        m_valid = 1'b0;
        m_have  = 1'b0;
        if (ms_if.pms_to_ms_bus.valid && ms_if.pms_to_ms_bus.req_ok) owners.push_back(0);
      end else if (exp_allowin) begin
        m_valid = ms_if.pms_to_ms_bus.valid;
        m_instr = ms_if.pms_to_ms_bus;
        m_have  = 1'b0;
        if (ms_if.pms_to_ms_bus.valid && ms_if.pms_to_ms_bus.req_ok) owners.push_back(1);
      end else if (owner == 1) begin
        m_have = 1'b1;
        m_data = ms_if.data_rdata;
      end
    end
  end

  task automatic applyStimulus(input pms_to_ms_bus_t b, input logic ws, input logic dok,
                               input logic [31:0] rd, input logic fl);
    @(posedge clk);
    #1;
    ms_if.pms_to_ms_bus     = b;
    ms_if.ws_allowin        = ws;
    ms_if.data_data_ok      = dok;
    ms_if.data_rdata        = rd;
    ms_if.pipeline_flush.ex = fl;
    ms_if.pipeline_flush.eret = 1'b0;
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [6:0]     vop[8];
  logic [31:0]    vaddr[8];
  logic [31:0]    vdata[8];
  logic [31:0]    vexp[8];
  pms_to_ms_bus_t nop;
  pms_to_ms_bus_t tmp;

  initial begin
    nop = '0;
    vop[0] = OP_LBU; vaddr[0] = 32'h0000_2001; vdata[0] = 32'h80FF_1234; vexp[0] = 32'h0000_0012;
    vop[1] = OP_LB;  vaddr[1] = 32'h0000_2002; vdata[1] = 32'h80FF_1234; vexp[1] = 32'hFFFF_FFFF;
    vop[2] = OP_LH;  vaddr[2] = 32'h0000_2000; vdata[2] = 32'h1234_ABCD; vexp[2] = 32'hFFFF_ABCD;
    vop[3] = OP_LHU; vaddr[3] = 32'h0000_2002; vdata[3] = 32'h1234_ABCD; vexp[3] = 32'h0000_1234;
    vop[4] = OP_LW;  vaddr[4] = 32'h0000_2000; vdata[4] = 32'hA5A5_0F0F; vexp[4] = 32'hA5A5_0F0F;
    vop[5] = OP_LWL; vaddr[5] = 32'h0000_2001; vdata[5] = 32'h1122_3344; vexp[5] = 32'h3344_0000;
    vop[6] = OP_LWR; vaddr[6] = 32'h0000_2001; vdata[6] = 32'h1122_3344; vexp[6] = 32'h0011_2233;
    vop[7] = OP_LWR; vaddr[7] = 32'h0000_2003; vdata[7] = 32'h1122_3344; vexp[7] = 32'h0000_0011;

    reset = 1'b1;
    ms_if.pms_to_ms_bus  = '0;
    ms_if.ws_allowin     = 1'b1;
    ms_if.data_data_ok   = 1'b0;
    ms_if.data_rdata     = '0;
    ms_if.pipeline_flush = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset_allowin", 32'(ms_if.ms_allowin), 32'd1);
    checkOutput("reset_ws_valid", 32'(ms_if.ms_to_ws_bus.valid), 32'd0);
    checkOutput("reset_fwd_dest", 32'(ms_if.ms_forward_bus.dest), 32'd0);
    checkOutput("reset_load_pending", 32'(ms_if.ms_forward_bus.load_pending), 32'd0);

    $display("[TB] lb with response one cycle after entry");
    applyStimulus(mkLoad(OP_LB, 32'h0000_1003, 5'd3, 32'hBFC0_0000), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lb_wait_valid", 32'(ms_if.ms_to_ws_bus.valid), 32'd0);
    applyStimulus(nop, 1'b1, 1'b1, 32'h80FF_1234, 1'b0);
    @(negedge clk);
    checkOutput("lb_valid", 32'(ms_if.ms_to_ws_bus.valid), 32'd1);
    checkOutput("lb_result", ms_if.ms_to_ws_bus.final_result, 32'hFFFF_FF80);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("lb_single_handoff", 32'(ms_if.ms_to_ws_bus.valid), 32'd0);

    $display("[TB] lhu held by write-back");
    applyStimulus(mkLoad(OP_LHU, 32'h0000_1002, 5'd4, 32'hBFC0_0004), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b0, 1'b1, 32'h8001_0000, 1'b0);
    @(negedge clk);
    checkOutput("lhu_allowin_hit", 32'(ms_if.ms_allowin), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(nop, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      checkOutput("lhu_allowin_hold", 32'(ms_if.ms_allowin), 32'd0);
      checkOutput("lhu_result_hold", ms_if.ms_to_ws_bus.final_result, 32'h0000_8001);
    end
    applyStimulus(nop, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    checkOutput("lhu_result", ms_if.ms_to_ws_bus.final_result, 32'h0000_8001);
    checkOutput("lhu_allowin_release", 32'(ms_if.ms_allowin), 32'd1);

    $display("[TB] flush while lw waits, stale response dropped");
    applyStimulus(mkLoad(OP_LW, 32'h0000_1010, 5'd5, 32'hBFC0_0008), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(mkLoad(OP_LW, 32'h0000_1014, 5'd6, 32'hBFC0_0100), 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("flush_discard_one", 32'(u_dut.discard_cnt), 32'd1);
    applyStimulus(nop, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checkOutput("stale_not_delivered", 32'(ms_if.ms_to_ws_bus.valid), 32'd0);
    applyStimulus(nop, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checkOutput("second_lw_result", ms_if.ms_to_ws_bus.final_result, 32'h1234_5678);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("discard_back_zero", 32'(u_dut.discard_cnt), 32'd0);

    $display("[TB] flush coinciding with response");
    applyStimulus(mkLoad(OP_LW, 32'h0000_1020, 5'd7, 32'hBFC0_0010), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("flush_with_data_discard", 32'(u_dut.discard_cnt), 32'd0);

    $display("[TB] flush with a new request entering");
    applyStimulus(mkLoad(OP_LW, 32'h0000_1030, 5'd8, 32'hBFC0_0020), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(mkLoad(OP_LW, 32'h0000_1034, 5'd9, 32'hBFC0_0024), 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("double_stale_discard", 32'(u_dut.discard_cnt), 32'd2);
    applyStimulus(mkLoad(OP_LW, 32'h0000_1038, 5'd10, 32'hBFC0_0200), 1'b1, 1'b1, 32'h0000_0001, 1'b0);
    applyStimulus(nop, 1'b1, 1'b1, 32'h0000_0002, 1'b0);
    @(negedge clk);
    checkOutput("double_stale_blocked", 32'(ms_if.ms_to_ws_bus.valid), 32'd0);
    applyStimulus(nop, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    checkOutput("after_stale_result", ms_if.ms_to_ws_bus.final_result, 32'h0BAD_F00D);

    $display("[TB] non-load pass-through");
    applyStimulus(mkAlu(32'h0000_0010, 5'd11, 32'hBFC0_0030), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("alu_valid", 32'(ms_if.ms_to_ws_bus.valid), 32'd1);
    checkOutput("alu_result", ms_if.ms_to_ws_bus.final_result, 32'h0000_0010);
    checkOutput("alu_load_pending", 32'(ms_if.ms_forward_bus.load_pending), 32'd0);

    $display("[TB] exception and eret block side effects");
    tmp = mkAlu(32'h0, 5'd0, 32'hBFC0_0040);
    tmp.rf_we = 1'b0; tmp.exception.ex = 1'b1; tmp.exception.excode = 5'd4;
    applyStimulus(tmp, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("exc_wr_disable", 32'(ms_if.ms_wr_disable), 32'd1);
    tmp = mkAlu(32'h0, 5'd0, 32'hBFC0_0044);
    tmp.rf_we = 1'b0; tmp.c0_op.eret = 1'b1;
    applyStimulus(tmp, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("eret_wr_disable", 32'(ms_if.ms_wr_disable), 32'd1);

    $display("[TB] load forwarding");
    applyStimulus(mkLoad(OP_LW, 32'h0000_0100, 5'd12, 32'hBFC0_0050), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("fwd_wait_pending", 32'(ms_if.ms_forward_bus.load_pending), 32'd1);
    applyStimulus(nop, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
    @(negedge clk);
`ifdef MEM_LOAD_FWD_EN
    checkOutput("fwd_data_arrive", ms_if.ms_forward_bus.fwd_data, 32'hCAFE_0001);
    checkOutput("fwd_pending_arrive", 32'(ms_if.ms_forward_bus.load_pending), 32'd0);
`else
    checkOutput("fwd_data_arrive", ms_if.ms_forward_bus.fwd_data, 32'h0000_0100);
    checkOutput("fwd_pending_arrive", 32'(ms_if.ms_forward_bus.load_pending), 32'd1);
`endif

    $display("[TB] load format vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mkLoad(vop[i], vaddr[i], 5'd13, 32'hBFC0_0300 + 32'(i * 4)),
                    1'b1, 1'b0, '0, 1'b0);
      applyStimulus(nop, 1'b1, 1'b1, vdata[i], 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_result", i), ms_if.ms_to_ws_bus.final_result, vexp[i]);
    end

    $display("[TB] reset while a stale response is pending");
    applyStimulus(mkLoad(OP_LW, 32'h0000_1040, 5'd14, 32'hBFC0_0060), 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    reset = 1'b1;
    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_clears_discard", 32'(u_dut.discard_cnt), 32'd0);
    checkOutput("reset_mid_allowin", 32'(ms_if.ms_allowin), 32'd1);

    applyStimulus(nop, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-response stage of the five-stage-plus CPU pipeline, sitting between the pre-memory (request) stage and write-back. It accepts instructions whose data-SRAM request has already been address-accepted, waits for and captures the matching data response, aligns and sign/zero-extends load data, and forwards the final result to write-back and to the operand-forwarding network. It also absorbs stale data responses belonging to instructions killed by a flush.

## Interface
Parameters: none.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ws_allowin  in  1  write-back can accept an instruction this cycle
- ms_allowin  out  1  this stage can accept an instruction this cycle
- pms_to_ms_bus  in  pms_to_ms_bus_t  {valid, load_op[6:0], c0_op, c0_addr, req_ok, res_from_mem, res_to_mem, rf_we, dest[4:0], result[31:0], pc[31:0], exception, tlb_op}
- ms_to_ws_bus  out  ms_to_ws_bus_t  {valid, c0_op, c0_addr, rf_we, dest[4:0], final_result[31:0], pc[31:0], exception, tlb_op}
- ms_forward_bus  out  ms_forward_bus_t  {op_mfc0, load_pending, op_tlb, dest[4:0], fwd_data[31:0]}
- pipeline_flush  in  pipeline_flush_t  {ex, eret}; either bit kills this stage
- ms_wr_disable  out  1  valid & (exception.ex | pipeline_flush.eret-class c0_op); blocks younger side effects
- data_data_ok  in  1  data-SRAM response valid (in request order)
- data_rdata  in  32  response data

## Operation
- Registers: ms_valid, bus_r (captured pms_to_ms_bus when valid & ms_allowin), data_got, rdata_r, discard_cnt[1:0].
- Per-instruction state: WAIT (bus_r.req_ok & !data_got), READY (!req_ok, or data_got). Response consumption priority: data_data_ok with discard_cnt≠0 decrements discard_cnt and is not delivered; otherwise it completes WAIT (rdata captured into rdata_r, data_got←1 if ws_allowin low).
- ms_ready_go = !bus_r.req_ok | data_got | (data_data_ok & discard_cnt==0).
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin). ms_to_ws valid = ms_valid & ms_ready_go.
- Flush: ms_valid←0; data_got←0; if ms_valid & bus_r.req_ok & !data_got & !(data_data_ok & discard_cnt==0), discard_cnt←discard_cnt+1. Also +1 if incoming bus is valid with req_ok at the flush edge (its response is stale). Increment and decrement in one cycle net zero. discard_cnt saturates at 3 (assertion if exceeded).
- Load data source: data_got ? rdata_r : data_rdata. Offset = bus_r.result[1:0] (address). load_op one-hot order: lb, lbu, lh, lhu, lw, lwl, lwr.
- lb/lbu: byte at offset, sign/zero-extend. lh/lhu: halfword at offset[1] (offset[0]=0 guaranteed upstream). lw: whole word. lwl/lwr: merged per MIPS rules with rt value carried in bus_r.result upper path is not available; these produce raw aligned bytes with rf byte-enable handled in write-back (final_result = shifted data).
- final_result = res_from_mem ? aligned load : bus_r.result.
- Exceptions: passed unchanged; an excepting instruction never has req_ok.

## Timing
- Reset: ms_valid=0, data_got=0, discard_cnt=0; ms_allowin=1, all valid outputs 0, ms_forward_bus dest=0, load_pending=0.
- Earliest response: cycle instruction first valid in MEM; zero-cycle pass-through data_data_ok→ms_to_ws_bus.
- Non-load: one cycle in stage when ws_allowin=1.
- Response arriving while ws_allowin=0: captured, instruction held; rdata_r stable until handoff.
- Reset mid-WAIT: discard_cnt cleared; memory side is reset simultaneously.

## Configuration
- MEM_LOAD_FWD_EN defined: ms_forward_bus.fwd_data = final_result, load_pending = valid & res_from_mem & !ms_ready_go (loaded data forwardable same cycle it arrives).
- Undefined: fwd_data = bus_r.result; load_pending = valid & res_from_mem for the whole MEM residency (consumers stall until write-back).

## Test plan
- lb at addr 0x..03, rdata 0x80FF_1234 with data_ok one cycle after entry, ws_allowin=1 -> final_result 0xFFFF_FF80, one valid handoff.
- lhu at addr 0x..02, rdata 0x8001_0000, ws_allowin=0 for 3 cycles after data_ok -> held, then final_result 0x0000_8001; ms_allowin low throughout hold.
- Flush while lw in WAIT, next lw enters, two data_ok pulses (0xDEAD_BEEF, 0x1234_5678) -> first discarded, second lw result 0x1234_5678, discard_cnt returns 0.
- Flush and data_data_ok in same cycle for waiting lw -> response consumed, discard_cnt stays 0.
- addiu result 0x0000_0010 with req_ok=0 -> passes in one cycle, final_result 0x10, load_pending 0.
- With MEM_LOAD_FWD_EN: lw waiting -> load_pending 1; on data_ok 0xCAFE_0001 same-cycle fwd_data 0xCAFE_0001, load_pending 0.
